vec_issue: RTL
==============

# vec_issue

Issue stage directly upstream of the vector register file. It accepts decoded vector instructions through a one-entry holding register and checks them against a write scoreboard and the input-FIFO state. It drives the register file read addresses in the issue cycle and presents the issued operation one cycle later, aligned with the synchronous read data. Register 0 is the FIFO-backed operand port: any instruction reading r0 consumes exactly one FIFO word.

## Interface
- WIDTH_ADDR, 4, register address width (2**WIDTH_ADDR registers)
- OPW, 4, opcode width
- CNT_W, 16, stall counter width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  holding register can accept
- in_op  in  OPW  opcode
- in_rd  in  WIDTH_ADDR  destination; 0 = no writeback
- in_ra  in  WIDTH_ADDR  source A
- in_rb  in  WIDTH_ADDR  source B
- stall  in  1  execute stage cannot take an issue this cycle
- fifo_empty  in  1  register-file input FIFO empty
- wb_valid  in  1  writeback completes this cycle
- wb_addr  in  WIDTH_ADDR  register being written back
- addra  out  WIDTH_ADDR  register file read address A
- addrb  out  WIDTH_ADDR  register file read address B
- rf_fifo_rd  out  1  pop request to the register-file FIFO, one pulse per issued r0-reading instruction
- issue_valid  out  1  operands valid on register file outputs this cycle
- issue_op  out  OPW  opcode of the issued instruction
- issue_rd  out  WIDTH_ADDR  destination of the issued instruction
- stall_cnt  out  CNT_W  saturating count of cycles with head valid but not issued

## Operation
- Holding register (head): loads when in_valid && in_ready. in_ready = !head_valid || issue_fire, with no combinational path from in_* to in_ready.
- Scoreboard: pending[2**WIDTH_ADDR] bits; bit 0 is always 0.
  - Set on issue_fire when head_rd != 0.
  - Cleared on wb_valid for wb_addr.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard: pending[head_ra] || pending[head_rb] || pending[head_rd] (RAW + WAW). No writeback bypass: a clear becomes visible the cycle after wb_valid.
- fifo_block: (head_ra == 0 || head_rb == 0) && fifo_empty.
- issue_fire = head_valid && !hazard && !fifo_block && !stall.
- addra/addrb always show head_ra/head_rb; they are 0 when head is empty.
- rf_fifo_rd = issue_fire && (head_ra == 0 || head_rb == 0). If both sources are r0, there is still a single pop and both operands receive the same word.
- stall_cnt increments when head_valid && !issue_fire and saturates at all-ones.
- wb_valid with wb_addr = 0 or to a non-pending register: no effect.

## Timing
- Reset (rstn = 0 at a clk edge): head_valid = 0, pending = 0, issue_valid = 0, issue_op = 0, issue_rd = 0, stall_cnt = 0.
- While in reset: in_ready = 1, addra = addrb = 0, rf_fifo_rd = 0.
- Reset mid-operation discards the head and all pending bits. In-flight writebacks arriving later are ignored.
- Accept at edge T → head valid in cycle T+1. Earliest issue_fire is in T+1, with addresses presented in T+1. issue_valid, issue_op and issue_rd are registered and asserted in T+2.
- Back-to-back: one issue per cycle when hazard-free. A new instruction loads in the same edge the head issues.
- Dependent instruction: issues no earlier than the cycle after the producer's wb_valid.

## Structure
- Shared package vec_pkg: instr_t struct {op, rd, ra, rb}, constants REG_FIFO = 0 and NREG = 2**WIDTH_ADDR.
- Sub-module vec_scoreboard holds the pending bit-vector with set/clear ports and set-wins priority. It exposes pending bits for three lookup addresses.

## Test plan
- Reset then single instruction op = 3, rd = 5, ra = 1, rb = 2 accepted at T → addra = 1, addrb = 2 at T+1; issue_valid = 1, issue_rd = 5 at T+2; pending[5] = 1.
- RAW: rd = 5 issued, then ra = 5 offered → head held, stall_cnt counts. wb_valid with wb_addr = 5 at cycle W → issue at W+1.
- FIFO: ra = 0 with fifo_empty = 1 for 4 cycles → no issue, stall_cnt = 4. fifo_empty drops → issue with rf_fifo_rd = 1 for exactly one cycle. Repeat with ra = rb = 0 → one pulse only.
- Same-cycle wb_valid(wb_addr = 7) and issue of rd = 7 → pending[7] remains 1.
- 10 independent instructions streamed → 10 consecutive issue_valid cycles, in_ready held 1. stall = 1 for 2 cycles mid-stream → exactly a 2-cycle gap with no loss or duplication.
- rstn = 0 with head valid and pending[3] = 1 → next cycle all outputs at reset values, pending = 0, a following ra = 3 instruction issues without stall.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector issue stage.
package vec_pkg;

    localparam int unsigned DEF_WIDTH_ADDR = 4;
    localparam int unsigned DEF_OPW        = 4;
    localparam int unsigned DEF_CNT_W      = 16;

    // Register 0 is the FIFO-backed operand port.
    localparam int unsigned REG_FIFO = 0;
    localparam int unsigned NREG     = 2 ** DEF_WIDTH_ADDR;

    typedef struct packed {
        logic [DEF_OPW-1:0]        op;
        logic [DEF_WIDTH_ADDR-1:0] rd;
        logic [DEF_WIDTH_ADDR-1:0] ra;
        logic [DEF_WIDTH_ADDR-1:0] rb;
    } instr_t;

endpackage

// File: rtl/vec_scoreboard.sv
// Pending-write scoreboard: one bit per register, set wins over a same-cycle clear.
module vec_scoreboard #(
    parameter int unsigned WIDTH_ADDR = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_set,
    input  logic [WIDTH_ADDR-1:0]      i_set_addr,
    input  logic                       i_clr,
    input  logic [WIDTH_ADDR-1:0]      i_clr_addr,
    input  logic [WIDTH_ADDR-1:0]      i_lk_a,
    input  logic [WIDTH_ADDR-1:0]      i_lk_b,
    input  logic [WIDTH_ADDR-1:0]      i_lk_d,
    output logic                       o_pend_a,
    output logic                       o_pend_b,
    output logic                       o_pend_d,
    output logic [2**WIDTH_ADDR-1:0]   o_pending
);

    localparam int unsigned NUM_REG = 2 ** WIDTH_ADDR;

    logic [NUM_REG-1:0] r_pending;
    logic [NUM_REG-1:0] w_set_mask;
    logic [NUM_REG-1:0] w_clr_mask;
    logic [NUM_REG-1:0] w_pending_next;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set) begin
            w_set_mask[i_set_addr] = 1'b1;
        end
        if (i_clr) begin
            w_clr_mask[i_clr_addr] = 1'b1;
        end
        w_pending_next    = (r_pending & ~w_clr_mask) | w_set_mask;
        // r0 never carries a writeback, so it can never be pending.
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign o_pend_a  = r_pending[i_lk_a];
    assign o_pend_b  = r_pending[i_lk_b];
    assign o_pend_d  = r_pending[i_lk_d];
    assign o_pending = r_pending;

endmodule

// File: rtl/vec_issue.sv
// Vector issue stage: one-entry holding register, scoreboard/FIFO gating, registered issue outputs.
module vec_issue
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = DEF_WIDTH_ADDR,
    parameter int unsigned OPW        = DEF_OPW,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPW-1:0]        in_op,
    input  logic [WIDTH_ADDR-1:0] in_rd,
    input  logic [WIDTH_ADDR-1:0] in_ra,
    input  logic [WIDTH_ADDR-1:0] in_rb,
    input  logic                  stall,
    input  logic                  fifo_empty,
    input  logic                  wb_valid,
    input  logic [WIDTH_ADDR-1:0] wb_addr,
    output logic [WIDTH_ADDR-1:0] addra,
    output logic [WIDTH_ADDR-1:0] addrb,
    output logic                  rf_fifo_rd,
    output logic                  issue_valid,
    output logic [OPW-1:0]        issue_op,
    output logic [WIDTH_ADDR-1:0] issue_rd,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int unsigned           NUM_REG   = 2 ** WIDTH_ADDR;
    localparam logic [WIDTH_ADDR-1:0] FIFO_ADDR = WIDTH_ADDR'(REG_FIFO);

    logic                  r_head_valid;
    logic [OPW-1:0]        r_head_op;
    logic [WIDTH_ADDR-1:0] r_head_rd;
    logic [WIDTH_ADDR-1:0] r_head_ra;
    logic [WIDTH_ADDR-1:0] r_head_rb;

    logic                  r_issue_valid;
    logic [OPW-1:0]        r_issue_op;
    logic [WIDTH_ADDR-1:0] r_issue_rd;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic                  w_pend_a;
    logic                  w_pend_b;
    logic                  w_pend_d;
    logic [NUM_REG-1:0]    w_pending;
    logic                  w_hazard;
    logic                  w_reads_fifo;
    logic                  w_fifo_block;
    logic                  w_issue_fire;
    logic                  w_accept;
    logic                  w_sb_set;

    vec_scoreboard #(
        .WIDTH_ADDR (WIDTH_ADDR)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .i_set      (w_sb_set),
        .i_set_addr (r_head_rd),
        .i_clr      (wb_valid),
        .i_clr_addr (wb_addr),
        .i_lk_a     (r_head_ra),
        .i_lk_b     (r_head_rb),
        .i_lk_d     (r_head_rd),
        .o_pend_a   (w_pend_a),
        .o_pend_b   (w_pend_b),
        .o_pend_d   (w_pend_d),
        .o_pending  (w_pending)
    );

    assign w_hazard     = w_pend_a || w_pend_b || w_pend_d;
    assign w_reads_fifo = (r_head_ra == FIFO_ADDR) || (r_head_rb == FIFO_ADDR);
    assign w_fifo_block = w_reads_fifo && fifo_empty;

    // Gated by rstn so nothing leaves the stage while reset is being sampled.
    assign w_issue_fire = rstn && r_head_valid && !w_hazard && !w_fifo_block && !stall;
    assign w_sb_set     = w_issue_fire && (r_head_rd != '0);

    assign in_ready   = !rstn || !r_head_valid || w_issue_fire;
    assign w_accept   = in_valid && in_ready;
    assign addra      = (rstn && r_head_valid) ? r_head_ra : '0;
    assign addrb      = (rstn && r_head_valid) ? r_head_rb : '0;
    assign rf_fifo_rd = w_issue_fire && w_reads_fifo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head_valid <= 1'b0;
            r_head_op    <= '0;
            r_head_rd    <= '0;
            r_head_ra    <= '0;
            r_head_rb    <= '0;
        end else if (w_accept) begin
            r_head_valid <= 1'b1;
            r_head_op    <= in_op;
            r_head_rd    <= in_rd;
            r_head_ra    <= in_ra;
            r_head_rb    <= in_rb;
        end else if (w_issue_fire) begin
            r_head_valid <= 1'b0;
        end
    end

    // Issue outputs trail the fire cycle by one to line up with synchronous read data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_rd    <= '0;
        end else begin
            r_issue_valid <= w_issue_fire;
            if (w_issue_fire) begin
                r_issue_op <= r_head_op;
                r_issue_rd <= r_head_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (r_head_valid && !w_issue_fire && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_op    = r_issue_op;
    assign issue_rd    = r_issue_rd;
    assign stall_cnt   = r_stall_cnt;

endmodule
